// File: rtl/cube.sv
// cube: fully pipelined integer cuber, result = num^3 mod 2^WIDTH.
// Accepts one operand per clock and has no handshake. The operand captured at
// edge N appears on result just after edge N+3.
//
// Ports:
//   clock  - rising-edge clock for all registers
//   reset  - asynchronous, active-low; clears every pipeline register
//   num    - operand, sampled on every rising edge
//   result - registered cube of the operand captured 3 edges earlier
module cube #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] num,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] a0;   // input register
  logic [WIDTH-1:0] a1;   // operand delayed to line up with sq1
  logic [WIDTH-1:0] sq1;  // a0^2, low WIDTH bits
  logic [WIDTH-1:0] cb2;  // sq1*a1, low WIDTH bits

  // Every product is taken in WIDTH-bit context. Only the low half is kept,
  // so the wide product is never built. Modular truncation keeps the result
  // correct for two's-complement operands as well.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a0     <= '0;
      a1     <= '0;
      sq1    <= '0;
      cb2    <= '0;
      result <= '0;
    end else begin
      a0     <= num;
      sq1    <= a0 * a0;
      a1     <= a0;
      cb2    <= sq1 * a1;
      result <= cb2;
    end
  end

endmodule

// File: tb/tb_cube.sv
// tb_cube: scoreboard bench for cube. Stimulus pushes each operand's expected
// cube together with the edge count at which it becomes visible. A monitor
// samples result on every falling edge and pops and compares due entries.
module tb_cube;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] num   = '0;
  logic [W-1:0] result;

  cube #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .num(num), .result(result));

  always #5 clock = ~clock;

  typedef struct {
    int           due;
    logic [W-1:0] exp;
    logic [W-1:0] opnd;
  } item_t;

  item_t q[$];
  int    ecnt   = 0;
  int    errors = 0;
  int    checks = 0;
  bit    done   = 1'b0;

  always @(posedge clock) ecnt <= ecnt + 1;

  // The monitor compares the sample against the entry due at this edge count.
  // An entry that is past due without being seen also counts as a failure.
  always @(negedge clock) begin
    while (q.size() > 0 && q[0].due < ecnt) begin
      checks++; errors++;
      $display("FAIL missed num=%0d due=%0d now=%0d", q[0].opnd, q[0].due, ecnt);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].due == ecnt) begin
      checks++;
      if (result !== q[0].exp) begin
        errors++;
        $display("FAIL cube num=%0d edge=%0d got=%0d exp=%0d", q[0].opnd, ecnt, result, q[0].exp);
      end
      void'(q.pop_front());
    end
  end

  task automatic direct(input string name, input logic [W-1:0] exp);
    checks++;
    if (result !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, result, exp);
    end
  endtask

  // Drive one operand for the next capture edge and record its expected cube.
  task automatic step(input logic [W-1:0] v, input logic [W-1:0] exp);
    item_t it;
    @(negedge clock);
    num    = v;
    it.due = ecnt + 4;
    it.exp = exp;
    it.opnd = v;
    q.push_back(it);
  endtask

  // Expect zeros on result for edge counts lo..hi, which covers a cleared pipeline.
  task automatic zeros(input int lo, input int hi);
    item_t it;
    for (int d = lo; d <= hi; d++) begin
      it.due = d; it.exp = '0; it.opnd = '0;
      q.push_back(it);
    end
  endtask

  logic [W-1:0] wr_in  [4] = '{32'd1625, 32'd1626, 32'd2048, 32'hFFFF_FFFF};
  logic [W-1:0] wr_out [4] = '{32'd4291015625, 32'd3975080, 32'd0, 32'hFFFF_FFFF};
  logic [W-1:0] st_out [8] = '{32'd1, 32'd8, 32'd27, 32'd64, 32'd125, 32'd216, 32'd343, 32'd512};

  initial begin
    // Reset held low: result must stay 0 across several edges.
    repeat (3) begin
      @(negedge clock);
      direct("reset_hold", '0);
    end
    #1 reset = 1'b1;
    zeros(ecnt + 1, ecnt + 4);

    // Single operand, then zeros.
    step(32'd2, 32'd8);
    step(32'd0, 32'd0);
    step(32'd0, 32'd0);

    // Streaming 1..8.
    for (int i = 0; i < 8; i++) step(W'(i + 1), st_out[i]);

    // Wrap-around vectors.
    for (int i = 0; i < 4; i++) step(wr_in[i], wr_out[i]);

    // Mid-stream reset with nonzero data in flight.
    step(32'd10, 32'd1000);
    step(32'd11, 32'd1331);
    step(32'd12, 32'd1728);
    @(posedge clock);
    #2 reset = 1'b0;
    #1 direct("reset_async", '0);
    q.delete();
    zeros(ecnt, ecnt + 3);
    step(32'd0, 32'd0);
    @(posedge clock);
    #1 direct("reset_low_edge", '0);
    #1 reset = 1'b1;
    step(32'd7, 32'd343);
    step(32'd0, 32'd0);

    // Hold num=3 for 10 cycles.
    repeat (10) step(32'd3, 32'd27);
    repeat (4) step(32'd0, 32'd0);

    // Drain with a bound.
    for (int c = 0; c < 20 && q.size() > 0; c++) @(negedge clock);
    #1;
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    done = 1'b1;
  end

  initial begin
    fork
      wait (done);
      begin
        #20000;
        checks++; errors++;
        $display("FAIL timeout got=running exp=done");
      end
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
